// File: rtl/instr_fetch_pkg.sv
// Shared opcode constants, fetch FSM encodings and the fetch-buffer entry layout
// used by the fetch stage and its immediate generator.
package instr_fetch_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetchEntry_t;

endpackage

// File: rtl/instr_fetch_imm_gen.sv
// Combinational immediate generator: one 32-bit instruction word in, the
// sign-extended immediate for its encoding format out (0 for R-type/unknown).
module imm_gen
    import instr_fetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:                 imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                             instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm = {instr[31:12], 12'b0};
            OP_JAL:                   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                             instr[30:21], 1'b0};
            OP_R:                     imm = '0;
            default:                  imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time, buffers
// responses in a small FIFO and presents split fields plus immediate to the decoder.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [4:0]  regNum0,
    output logic [4:0]  regNum1,
    output logic [4:0]  regWriteNum,
    output logic [31:0] imm
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    logic [1:0]       stateReg, stateNext;
    logic [31:0]      pcReg, pcNext;
    logic [31:0]      reqPcReg, reqPcNext;
    logic [PTR_W-1:0] headReg, tailReg;
    logic [CNT_W-1:0] countReg, countNext;
    fetchEntry_t      fifoMem [BUF_DEPTH];
    fetchEntry_t      headEntry;
    logic [31:0]      headInstr;
    logic             doPush, doPop;

    assign doPop  = dec_valid && dec_ready;
    assign doPush = (stateReg == ST_WAIT) && imem_resp_valid && !redirect_valid;

    always_comb begin
        countNext = countReg;
        if (redirect_valid)
            countNext = '0;
        else if (doPush && !doPop)
            countNext = countReg + CNT_W'(1);
        else if (!doPush && doPop)
            countNext = countReg - CNT_W'(1);
    end

    always_comb begin
        stateNext = stateReg;
        pcNext    = pcReg;
        reqPcNext = reqPcReg;
        case (stateReg)
            // A request only leaves IDLE when its response already has a slot.
            ST_IDLE:  if (countReg < DEPTH_CNT) stateNext = ST_REQ;
            ST_REQ:   if (imem_req_ready) begin
                          stateNext = ST_WAIT;
                          reqPcNext = pcReg;
                          pcNext    = pcReg + 32'd4;
                      end
            ST_WAIT:  if (imem_resp_valid)
                          stateNext = (countNext < DEPTH_CNT) ? ST_REQ : ST_IDLE;
            ST_DRAIN: if (imem_resp_valid) stateNext = ST_REQ;
            default:  stateNext = ST_IDLE;
        endcase

        if (redirect_valid) begin
            pcNext = redirect_pc & ~32'h3;
            case (stateReg)
                ST_IDLE:  stateNext = ST_REQ;
                ST_REQ:   stateNext = imem_req_ready  ? ST_DRAIN : ST_REQ;
                ST_WAIT:  stateNext = imem_resp_valid ? ST_REQ   : ST_DRAIN;
                // The stale response arriving alongside the redirect is the one being drained.
                ST_DRAIN: stateNext = imem_resp_valid ? ST_REQ   : ST_DRAIN;
                default:  stateNext = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= ST_IDLE;
            pcReg    <= RESET_PC;
            reqPcReg <= RESET_PC;
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
        end else begin
            stateReg <= stateNext;
            pcReg    <= pcNext;
            reqPcReg <= reqPcNext;
            countReg <= countNext;
            if (redirect_valid) begin
                headReg <= '0;
                tailReg <= '0;
            end else begin
                if (doPush) tailReg <= tailReg + PTR_W'(1);
                if (doPop)  headReg <= headReg + PTR_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : gEntry
            always_ff @(posedge clk) begin
                if (doPush && tailReg == PTR_W'(gi))
                    fifoMem[gi] <= '{pc: reqPcReg, instr: imem_resp_data};
            end
        end
    endgenerate

    assign imem_req_valid = (stateReg == ST_REQ);
    assign imem_addr      = pcReg;
    assign dec_valid      = (countReg != '0);

    // Gating the head word to zero makes every decoded field and imm read 0 when empty.
    assign headEntry   = fifoMem[headReg];
    assign headInstr   = dec_valid ? headEntry.instr : 32'h0;
    assign dec_pc      = dec_valid ? headEntry.pc : 32'h0;
    assign opcode      = headInstr[6:0];
    assign func3       = headInstr[14:12];
    assign func7       = headInstr[31:25];
    assign regNum0     = headInstr[19:15];
    assign regNum1     = headInstr[24:20];
    assign regWriteNum = headInstr[11:7];

    imm_gen uImmGen (
        .instr (headInstr),
        .imm   (imm)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model with configurable latency,
// pc scoreboard on requests/pops, and a vector table of words with expected immediates.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_pc;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [4:0]  regNum0, regNum1, regWriteNum;
    logic [31:0] imm;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_pc          (dec_pc),
        .opcode          (opcode),
        .func3           (func3),
        .func7           (func7),
        .regNum0         (regNum0),
        .regNum1         (regNum1),
        .regWriteNum     (regWriteNum),
        .imm             (imm)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
    } vec_t;

    vec_t        vecs [16];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ [$];
    logic [31:0] expReqAddr = 32'h0;
    int          respDelay = 1;
    bit          pendValid = 1'b0;
    int          pendCnt = 0;
    logic [31:0] pendAddr = 32'h0;
    bit          lastAccepted = 1'b0;
    logic [31:0] lastAccAddr = 32'h0;
    bit          lastPop = 1'b0;
    logic [31:0] lastPopPc = 32'h0;
    int          popCount = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, update scoreboard, then advance the memory model after posedge.
    task automatic tick();
        bit acc, pop, redir, rs;
        logic [31:0] pc, w, accAddr;
        bit ok;
        @(negedge clk);
        rs      = rst;
        acc     = imem_req_valid && imem_req_ready;
        pop     = dec_valid && dec_ready;
        redir   = redirect_valid;
        accAddr = imem_addr;
        lastAccepted = acc && !rs;
        lastAccAddr  = accAddr;
        lastPop      = pop && !rs;
        if (rs) begin
            expQ.delete();
            expReqAddr = 32'h0;
        end else begin
            if (pop) begin
                popCount++;
                lastPopPc = dec_pc;
                if (expQ.size() == 0) begin
                    check(1'b0, "pop_unexpected", dec_pc, 32'h0);
                end else begin
                    pc = expQ.pop_front();
                    w  = vecs[pc[5:2]].instr;
                    ok = (dec_pc == pc) && (opcode == w[6:0]) && (func3 == w[14:12]) &&
                         (func7 == w[31:25]) && (regNum0 == w[19:15]) && (regNum1 == w[24:20]) &&
                         (regWriteNum == w[11:7]) && (imm == vecs[pc[5:2]].imm);
                    checks++;
                    $display("pop pc=0x%08h word=0x%08h imm=0x%08h", dec_pc, w, imm);
                    if (!ok) begin
                        errors++;
                        $display("FAIL dec_word: got pc=0x%08h op=0x%02h rs1=%0d rs2=%0d rd=%0d imm=0x%08h expected pc=0x%08h word=0x%08h imm=0x%08h",
                                 dec_pc, opcode, regNum0, regNum1, regWriteNum, imm, pc, w, vecs[pc[5:2]].imm);
                    end
                end
            end
            if (acc) begin
                check(accAddr == expReqAddr, "req_addr", accAddr, expReqAddr);
                $display("req addr=0x%08h", accAddr);
                expReqAddr = expReqAddr + 32'd4;
                if (!redir) expQ.push_back(accAddr);
            end
            if (redir) begin
                expQ.delete();
                expReqAddr = redirect_pc & ~32'h3;
            end
        end
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (rs) begin
            pendValid = 1'b0;
        end else begin
            if (acc) begin
                pendValid = 1'b1;
                pendCnt   = respDelay;
                pendAddr  = accAddr;
            end
            if (pendValid) begin
                pendCnt--;
                if (pendCnt <= 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = vecs[pendAddr[5:2]].instr;
                    pendValid       = 1'b0;
                end
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 32'h1, 32'h0);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{32'hFE010113, 32'hFFFF_FFE0};  // addi sp,sp,-32
        vecs[1]  = '{32'h40505013, 32'h0000_0405};  // srai, imm[10]=1
        vecs[2]  = '{32'hFE000EE3, 32'hFFFF_FFFC};  // B-type -4
        vecs[3]  = '{32'h0080006F, 32'h0000_0008};  // jal +8
        vecs[4]  = '{32'h12345037, 32'h1234_5000};  // lui
        vecs[5]  = '{32'h00B50533, 32'h0000_0000};  // add (R)
        vecs[6]  = '{32'h00812623, 32'h0000_000C};  // sw +12
        vecs[7]  = '{32'hFFC4A303, 32'hFFFF_FFFC};  // lw -4
        vecs[8]  = '{32'h00000097, 32'h0000_0000};  // auipc 0
        vecs[9]  = '{32'h000080E7, 32'h0000_0000};  // jalr 0
        vecs[10] = '{32'h00000000, 32'h0000_0000};  // unknown opcode
        vecs[11] = '{32'h80000537, 32'h8000_0000};  // lui top bit
        vecs[12] = '{32'hFFDFF06F, 32'hFFFF_FFFC};  // jal -4
        vecs[13] = '{32'h00208463, 32'h0000_0008};  // beq +8
        vecs[14] = '{32'h80000023, 32'hFFFF_F800};  // sb -2048
        vecs[15] = '{32'h7FF00013, 32'h0000_07FF};  // addi +2047

        rst = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        dec_ready       = 1'b1;

        // Reset state
        repeat (3) tick();
        check(imem_req_valid == 1'b0, "rst_req_valid", 32'(imem_req_valid), 32'h0);
        check(dec_valid == 1'b0, "rst_dec_valid", 32'(dec_valid), 32'h0);
        check(imem_addr == 32'h0, "rst_pc", imem_addr, 32'h0);
        check(imm == 32'h0 && opcode == 7'h0 && regWriteNum == 5'h0, "rst_fields", imm, 32'h0);
        rst = 1'b0;

        // Streaming: every vector word decoded in address order
        popCount = 0;
        for (int i = 0; i < 40 && popCount < 16; i++) tick();
        check(popCount >= 16, "stream_pops_in_40", 32'(popCount), 32'd16);

        // Decoder stalled: exactly two requests, then fetch resumes at 0x8
        doReset();
        dec_ready = 1'b0;
        begin
            int accCount = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (lastAccepted) accCount++;
            end
            check(accCount == 2, "stall_req_count", 32'(accCount), 32'd2);
        end
        check(imem_req_valid == 1'b0, "stall_req_valid", 32'(imem_req_valid), 32'h0);
        dec_ready = 1'b1;
        begin
            int i = 0;
            do begin tick(); i++; end while (!lastAccepted && i < 20);
        end
        check(lastAccepted && lastAccAddr == 32'h8, "resume_addr", lastAccAddr, 32'h8);

        // Redirect while WAIT: late response discarded, fetch restarts at 0x100
        doReset();
        dec_ready = 1'b0;
        respDelay = 1;
        for (int i = 0; i < 10 && !dec_valid; i++) tick();
        check(dec_valid == 1'b1, "pre_redirect_fill", 32'(dec_valid), 32'h1);
        respDelay = 6;
        begin
            int i = 0;
            do begin tick(); i++; end while (!lastAccepted && i < 10);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        respDelay      = 1;
        check(dec_valid == 1'b0, "flush_dec_valid", 32'(dec_valid), 32'h0);
        check(imem_req_valid == 1'b0, "drain_req_valid", 32'(imem_req_valid), 32'h0);
        dec_ready = 1'b1;
        begin
            int i = 0;
            do begin tick(); i++; end while (!lastPop && i < 30);
        end
        check(lastPop && lastPopPc == 32'h100, "redirect_first_pc", lastPopPc, 32'h100);

        // Redirect coinciding with a response and a decoder pop
        doReset();
        dec_ready = 1'b0;
        for (int i = 0; i < 20 && !(imem_resp_valid && dec_valid); i++) tick();
        check(imem_resp_valid && dec_valid, "coincide_setup", 32'(imem_resp_valid), 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        dec_ready      = 1'b1;
        tick();
        check(lastPop == 1'b1, "coincide_pop", 32'(lastPop), 32'h1);
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        check(dec_valid == 1'b0, "coincide_flush", 32'(dec_valid), 32'h0);
        dec_ready = 1'b1;
        begin
            int i = 0;
            do begin tick(); i++; end while (!lastPop && i < 20);
        end
        check(lastPop && lastPopPc == 32'h200, "coincide_next_pc", lastPopPc, 32'h200);

        // PC wrap past 0xFFFF_FFFC; low redirect bits ignored
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        begin
            int i = 0;
            do begin tick(); i++; end while (!lastPop && i < 20);
        end
        check(lastPop && lastPopPc == 32'hFFFF_FFFC, "wrap_first_pc", lastPopPc, 32'hFFFF_FFFC);
        begin
            int i = 0;
            do begin tick(); i++; end while (!lastPop && i < 20);
        end
        check(lastPop && lastPopPc == 32'h0, "wrap_second_pc", lastPopPc, 32'h0);

        // Reset asserted while a request is pending
        imem_req_ready = 1'b0;
        for (int i = 0; i < 10 && !imem_req_valid; i++) tick();
        check(imem_req_valid == 1'b1, "req_hold_setup", 32'(imem_req_valid), 32'h1);
        rst = 1'b1;
        tick();
        check(imem_req_valid == 1'b0, "rst_in_req_valid", 32'(imem_req_valid), 32'h0);
        check(imem_addr == 32'h0, "rst_in_req_pc", imem_addr, 32'h0);
        rst = 1'b0;
        imem_req_ready = 1'b1;
        begin
            int i = 0;
            do begin tick(); i++; end while (!lastPop && i < 20);
        end
        check(lastPop && lastPopPc == 32'h0, "post_reset_pc", lastPopPc, 32'h0);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
